// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for the master-slave JK flip-flop: a FIFO of {op, rep}
// commands replayed on registered j/k, plus a shadow of the downstream q.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_rep,
  output logic                     j,
  output logic                     k,
  output logic                     busy,
  output logic                     q_exp,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + CNT_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic             r_j;
  logic             r_k;
  logic             r_q;

  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;

  // Ready comes only from the registered count, so a full FIFO never refills
  // on the same edge it pops.
  assign cmd_ready = (r_count < FULL_CNT) && rst_n;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_count != '0) && ((r_state == S_IDLE) || (r_rem == '0));
  assign w_head    = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it out of reset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_op, cmd_rep};
  end

  // NOTE: every register here uses non-blocking assignment so all of them
  // see pre-edge values, e.g. q_exp follows the j/k driven before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case ({r_j, r_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase

      if (w_pop) begin
        {r_j, r_k} <= w_head[EW-1 -: 2];
        r_rem      <= w_head[CNT_W-1:0];
        r_state    <= S_ISSUE;
      end else if ((r_state == S_ISSUE) && (r_rem != '0)) begin
        r_rem <= r_rem - 1'b1;
      end else begin
        r_state <= S_IDLE;
        r_j     <= 1'b0;
        r_k     <= 1'b0;
      end
    end
  end

  assign j          = r_j;
  assign k          = r_k;
  assign q_exp      = r_q;
  assign fifo_count = r_count;
  assign busy       = (r_state == S_ISSUE) || (r_count != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: hand-computed vector table for the basic
// sequences, then a cycle model with an expected-output queue for the rest.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [CNT_W-1:0] cmd_rep = '0;
  logic             j, k, busy, q_exp;
  logic [CW-1:0]    fifo_count;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rep(cmd_rep), .j(j), .k(k), .busy(busy),
    .q_exp(q_exp), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic          j, k, q, busy, ready;
    logic [CW-1:0] count;
  } exp_t;

  typedef struct {
    logic             rst;
    logic             valid;
    logic [1:0]       op;
    logic [CNT_W-1:0] rep;
    exp_t             e;
  } vec_t;

  typedef struct {
    logic [1:0]       op;
    logic [CNT_W-1:0] rep;
  } cmd_t;

  int n_vec = 0;
  int n_err = 0;
  bit saw_full = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    check({tag, ".j"}, j, e.j);
    check({tag, ".k"}, k, e.k);
    check({tag, ".q_exp"}, q_exp, e.q);
    check({tag, ".busy"}, busy, e.busy);
    check({tag, ".ready"}, cmd_ready, e.ready);
    check({tag, ".count"}, fifo_count, e.count);
  endtask

  // Reference model: queue of pending commands plus the issuing command.
  cmd_t m_fifo[$];
  exp_t exp_q[$];
  bit   m_iss;
  int   m_rem;
  logic m_j, m_k, m_q;

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_iss = 0; m_rem = 0; m_j = 0; m_k = 0; m_q = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.j = m_j; e.k = m_k; e.q = m_q;
    e.busy  = m_iss || (m_fifo.size() != 0);
    e.ready = m_fifo.size() < DEPTH;
    e.count = CW'(m_fifo.size());
    return e;
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] rep,
                      output bit acc);
    cmd_t c;
    acc = v && (m_fifo.size() < DEPTH);
    cmd_valid = v; cmd_op = op; cmd_rep = rep;
    case ({m_j, m_k})
      2'b01:   m_q = 1'b0;
      2'b10:   m_q = 1'b1;
      2'b11:   m_q = ~m_q;
      default: ;
    endcase
    if (!m_iss || m_rem == 0) begin
      if (m_fifo.size() != 0) begin
        c = m_fifo.pop_front();
        {m_j, m_k} = c.op; m_rem = int'(c.rep); m_iss = 1;
      end else begin
        m_iss = 0; m_j = 0; m_k = 0;
      end
    end else begin
      m_rem--;
    end
    if (acc) begin
      c.op = op; c.rep = rep;
      m_fifo.push_back(c);
    end
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    cmp("model", exp_q.pop_front());
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while ((m_iss || m_fifo.size() != 0) && n < 200) begin
      step(1'b0, 2'b00, '0, acc);
      n++;
    end
    check("drain_bound", n < 200, 1);
    step(1'b0, 2'b00, '0, acc);
  endtask

  task automatic run(input cmd_t pend[$], input bit gaps);
    bit   acc;
    logic v;
    int   guard = 0;
    while (pend.size() != 0 && guard < 1000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(v, pend[0].op, pend[0].rep, acc);
      if (acc) void'(pend.pop_front());
      if (fifo_count == CW'(DEPTH) && !cmd_ready) saw_full = 1;
      check("count_le_depth", fifo_count <= CW'(DEPTH), 1);
      guard++;
    end
    check("run_bound", pend.size() == 0, 1);
    drain();
  endtask

  task automatic do_reset();
    cmd_valid = 0;
    rst_n = 0;
    #1;
    cmp("in_reset", '{j:0, k:0, q:0, busy:0, ready:0, count:'0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    #1;
    cmp("post_reset", '{j:0, k:0, q:0, busy:0, ready:1, count:'0});
  endtask

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic v, input logic [1:0] op,
                              input logic [CNT_W-1:0] rep, input logic ej, input logic ek,
                              input logic eq, input logic eb, input logic er, input int ec);
    vec_t t;
    t.rst = rst; t.valid = v; t.op = op; t.rep = rep;
    t.e = '{j:ej, k:ek, q:eq, busy:eb, ready:er, count:CW'(ec)};
    tbl.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t cmds[$];
    cmd_t c;
    bit   acc;

    // Test 1: SET rep=0
    add(0, 1, 2'b10, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 2'b00, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0);
    // Test 2: reset, then TOGGLE rep=3 from q=0
    add(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 2'b11, 3, 0, 0, 0, 1, 1, 1);
    add(0, 0, 2'b00, 0, 1, 1, 0, 1, 1, 0);
    add(0, 0, 2'b00, 0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 2'b00, 0, 1, 1, 0, 1, 1, 0);
    add(0, 0, 2'b00, 0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    // Test 4: RESET rep=1 then SET rep=0, back to back
    add(0, 1, 2'b01, 1, 0, 0, 0, 1, 1, 1);
    add(0, 1, 2'b10, 0, 0, 1, 0, 1, 1, 1);
    add(0, 0, 2'b00, 0, 0, 1, 0, 1, 1, 1);
    add(0, 0, 2'b00, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        cmd_valid = tbl[i].valid; cmd_op = tbl[i].op; cmd_rep = tbl[i].rep;
        @(posedge clk); #1;
        cmp($sformatf("vec%0d", i), tbl[i].e);
      end
    end

    // Test 3: six commands with valid held high, first rep=7, forces a full FIFO
    do_reset();
    cmds.delete();
    c.op = 2'b10; c.rep = 7; cmds.push_back(c);
    c.op = 2'b01; c.rep = 0; cmds.push_back(c);
    c.op = 2'b11; c.rep = 1; cmds.push_back(c);
    c.op = 2'b00; c.rep = 2; cmds.push_back(c);
    c.op = 2'b10; c.rep = 0; cmds.push_back(c);
    c.op = 2'b11; c.rep = 2; cmds.push_back(c);
    saw_full = 0;
    run(cmds, 0);
    check("t3_full_seen", saw_full, 1);

    // Test 5: asynchronous reset mid TOGGLE rep=15 with two entries queued
    do_reset();
    step(1'b1, 2'b11, 4'd15, acc);
    step(1'b1, 2'b01, 4'd2, acc);
    step(1'b1, 2'b10, 4'd5, acc);
    step(1'b0, 2'b00, '0, acc);
    step(1'b0, 2'b00, '0, acc);
    check("t5_pre_count", fifo_count, 2);
    #3;
    rst_n = 0;
    #1;
    cmp("t5_async", '{j:0, k:0, q:0, busy:0, ready:0, count:'0});
    @(posedge clk); #1;
    cmp("t5_held", '{j:0, k:0, q:0, busy:0, ready:0, count:'0});
    rst_n = 1;
    model_reset();
    #1;
    step(1'b1, 2'b10, 4'd0, acc);
    drain();
    check("t5_q_after_set", q_exp, 1);

    // Test 6: 3*DEPTH+1 random commands, pointer wrap, random valid gaps
    do_reset();
    cmds.delete();
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      c.op  = 2'($urandom_range(0, 3));
      c.rep = (i % 4 == 0) ? CNT_W'($urandom_range(0, 15)) : CNT_W'($urandom_range(0, 2));
      cmds.push_back(c);
    end
    run(cmds, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
